// File: rtl/scrambler_tx_if.sv
// Bus bundle between the MAC bit source, the transmit scrambler and the
// convolutional encoder: frame control, PSDU bit input, scrambled bit output and status.
interface scrambler_tx_if #(
    parameter int LEN_W = 12,
    parameter int PAD_W = 8
);
    logic             Scrambler_Start;
    logic [6:0]       Scrambler_Seed;
    logic [LEN_W-1:0] Scrambler_Length;
    logic [PAD_W-1:0] Scrambler_NPad;
    logic             Scrambler_DataIN;
    logic             Scrambler_DataIN_VALID;
    logic             Scrambler_DataIN_READY;
    logic             Scrambler_DataOUT;
    logic             Scrambler_DataVALID;
    logic             Scrambler_DataOUT_READY;
    logic             Scrambler_Busy;
    logic             Scrambler_Done;

    // Driver side: frame control, PSDU source and downstream ready.
    modport master (
        output Scrambler_Start,
        output Scrambler_Seed,
        output Scrambler_Length,
        output Scrambler_NPad,
        output Scrambler_DataIN,
        output Scrambler_DataIN_VALID,
        input  Scrambler_DataIN_READY,
        input  Scrambler_DataOUT,
        input  Scrambler_DataVALID,
        output Scrambler_DataOUT_READY,
        input  Scrambler_Busy,
        input  Scrambler_Done
    );

    modport slave (
        input  Scrambler_Start,
        input  Scrambler_Seed,
        input  Scrambler_Length,
        input  Scrambler_NPad,
        input  Scrambler_DataIN,
        input  Scrambler_DataIN_VALID,
        output Scrambler_DataIN_READY,
        output Scrambler_DataOUT,
        output Scrambler_DataVALID,
        input  Scrambler_DataOUT_READY,
        output Scrambler_Busy,
        output Scrambler_Done
    );
endinterface

// File: rtl/scrambler_tx.sv
// 802.11a transmit scrambler (x^7+x^4+1): emits SERVICE, scrambled PSDU, zeroed tail
// and scrambled pad bits for one frame through a single-stage valid/ready output register.
module scrambler_tx #(
    parameter int         LEN_W        = 12,
    parameter int         PAD_W        = 8,
    parameter logic [6:0] DEFAULT_SEED = 7'b1011101
) (
    input logic           clock,
    input logic           Scrambler_Reset_n,
    scrambler_tx_if.slave bus
);
    localparam int CNT_W = LEN_W + 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVICE,
        ST_DATA,
        ST_TAIL,
        ST_PAD,
        ST_FLUSH
    } state_t;

    state_t           state_reg;
    logic [6:0]       lfsr_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [PAD_W-1:0] pad_cnt_reg;
    logic [LEN_W-1:0] len_reg;
    logic [PAD_W-1:0] npad_reg;
    logic             dout_reg;
    logic             dvalid_reg;
    logic             done_reg;

    logic             load_ok;
    logic             produce;
    logic             in_bit;
    logic             fb;
    logic             out_bit;
    logic [6:0]       lfsr_next;
    logic [6:0]       seed_eff;
    logic [CNT_W-1:0] data_bits;
    logic             service_last;
    logic             data_last;
    logic             tail_last;
    logic             pad_last;

    assign fb           = lfsr_reg[6] ^ lfsr_reg[3];
    assign lfsr_next[0] = fb;

    generate
        for (genvar gi = 1; gi < 7; gi++) begin : g_lfsr_shift
            assign lfsr_next[gi] = lfsr_reg[gi-1];
        end
    endgenerate

    always_comb begin
        load_ok = !dvalid_reg || bus.Scrambler_DataOUT_READY;
        produce = 1'b0;
        case (state_reg)
            ST_SERVICE, ST_TAIL, ST_PAD: produce = load_ok;
            ST_DATA:                     produce = load_ok && bus.Scrambler_DataIN_VALID;
            default:                     produce = 1'b0;
        endcase
        in_bit  = (state_reg == ST_DATA) && bus.Scrambler_DataIN;
        // Tail bits still advance the LFSR but leave the block as zeros.
        out_bit = (state_reg == ST_TAIL) ? 1'b0 : (in_bit ^ fb);
    end

    always_comb begin
        seed_eff     = (bus.Scrambler_Seed == 7'd0) ? DEFAULT_SEED : bus.Scrambler_Seed;
        data_bits    = {len_reg, 3'b000};
        service_last = (bit_cnt_reg == CNT_W'(15));
        data_last    = (bit_cnt_reg == data_bits - CNT_W'(1));
        tail_last    = (bit_cnt_reg == CNT_W'(5));
        pad_last     = (pad_cnt_reg == npad_reg - PAD_W'(1));
    end

    always_ff @(posedge clock or negedge Scrambler_Reset_n) begin
        if (!Scrambler_Reset_n) begin
            state_reg   <= ST_IDLE;
            lfsr_reg    <= 7'd0;
            bit_cnt_reg <= '0;
            pad_cnt_reg <= '0;
            len_reg     <= '0;
            npad_reg    <= '0;
            dout_reg    <= 1'b0;
            dvalid_reg  <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            if (produce) begin
                dout_reg   <= out_bit;
                dvalid_reg <= 1'b1;
                lfsr_reg   <= lfsr_next;
            end else if (bus.Scrambler_DataOUT_READY) begin
                dvalid_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (bus.Scrambler_Start) begin
                        lfsr_reg    <= seed_eff;
                        len_reg     <= bus.Scrambler_Length;
                        npad_reg    <= bus.Scrambler_NPad;
                        bit_cnt_reg <= '0;
                        pad_cnt_reg <= '0;
                        state_reg   <= ST_SERVICE;
                    end
                end

                ST_SERVICE: begin
                    if (produce) begin
                        if (service_last) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= (len_reg != '0) ? ST_DATA : ST_TAIL;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end
                    end
                end

                ST_DATA: begin
                    if (produce) begin
                        if (data_last) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= ST_TAIL;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end
                    end
                end

                ST_TAIL: begin
                    if (produce) begin
                        if (tail_last) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= (npad_reg != '0) ? ST_PAD : ST_FLUSH;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end
                    end
                end

                ST_PAD: begin
                    if (produce) begin
                        if (pad_last) begin
                            pad_cnt_reg <= '0;
                            state_reg   <= ST_FLUSH;
                        end else begin
                            pad_cnt_reg <= pad_cnt_reg + PAD_W'(1);
                        end
                    end
                end

                ST_FLUSH: begin
                    // Output register is always full here; its acceptance ends the frame.
                    if (dvalid_reg && bus.Scrambler_DataOUT_READY) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.Scrambler_DataOUT      = dout_reg;
    assign bus.Scrambler_DataVALID    = dvalid_reg;
    assign bus.Scrambler_Done         = done_reg;
    assign bus.Scrambler_Busy         = (state_reg != ST_IDLE);
    assign bus.Scrambler_DataIN_READY = (state_reg == ST_DATA) && load_ok;
endmodule
